// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
//
// Captures register-file writebacks from the CPU writeback trace port into a
// first-word-fall-through FIFO. Each stored record carries a 16-bit sequence
// tag. The tag counts every qualifying writeback, including ones that had to
// be dropped, so a host-side consumer can find any gap in the trace.
//
// Ports:
//   clk, resetn           core clock, asynchronous active-low reset
//   debug_wb_pc           retiring instruction PC
//   debug_wb_rf_we        byte write enables (any set bit = a real write)
//   debug_wb_rf_wnum      destination register number
//   debug_wb_rf_wdata     write data
//   capture_en            level enable; low ignores every writeback
//   clr                   one-cycle flush of FIFO, overflow, drop_cnt and seq
//   out_valid/out_ready   head-of-FIFO handshake towards the consumer
//   out_pc/out_wnum/out_wdata/out_we/out_seq   head record fields
//   count                 occupancy, 0..DEPTH
//   overflow              sticky flag, set by any dropped record
//   drop_cnt              saturating count of dropped records
module wb_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter bit FILTER_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       debug_wb_pc,
    input  logic [3:0]        debug_wb_rf_we,
    input  logic [4:0]        debug_wb_rf_wnum,
    input  logic [31:0]       debug_wb_rf_wdata,
    input  logic              capture_en,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [4:0]        out_wnum,
    output logic [31:0]       out_wdata,
    output logic [3:0]        out_we,
    output logic [15:0]       out_seq,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam int              REC_W      = 32 + 5 + 32 + 4 + 16;

    // Record layout: {pc, wnum, wdata, we, seq}
    logic [REC_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       dropCnt_q, dropCnt_d;
    logic [15:0]       seq_q, seq_d;

    logic             cap;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [REC_W-1:0] headRec;

    // Qualify the writeback and decide push/pop/drop for this edge.
    // Full and empty come from the occupancy count, so the pointers can
    // simply wrap. A pop frees a slot in the same cycle, which lets a full
    // FIFO accept a new record without dropping it. clr overrides everything.
    always_comb begin
        cap   = capture_en & (|debug_wb_rf_we)
              & ~(FILTER_R0 & (debug_wb_rf_wnum == 5'd0));
        empty = (count_q == '0);
        full  = (count_q == FULL_COUNT);
        pop   = ~empty & out_ready;
        push  = cap & ~clr & (~full | pop);
        drop  = cap & ~clr & full & ~pop;
    end

    // Next-state logic for pointers, occupancy, drop accounting and the
    // sequence tag. The tag advances on every qualifying capture, whether
    // the record is stored or dropped.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        dropCnt_d  = dropCnt_q;
        seq_d      = seq_q;
        if (clr) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            dropCnt_d  = '0;
            seq_d      = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + ADDR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + ADDR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (ADDR_W + 1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (ADDR_W + 1)'(1);
            end
            if (cap) begin
                seq_d = seq_q + 16'd1;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (dropCnt_q != 16'hFFFF) begin
                    dropCnt_d = dropCnt_q + 16'd1;
                end
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropCnt_q  <= '0;
            seq_q      <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropCnt_q  <= dropCnt_d;
            seq_q      <= seq_d;
        end
    end

    // Storage has no reset. Unwritten slots are never visible because the
    // head fields are forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= {debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata,
                             debug_wb_rf_we, seq_q};
        end
    end

    // First-word-fall-through head. It only changes when rdPtr moves, so
    // the head record is stable while the consumer stalls.
    always_comb begin
        headRec = empty ? '0 : mem[rdPtr_q];
    end

    assign out_valid = ~empty;
    assign out_pc    = headRec[REC_W-1 -: 32];
    assign out_wnum  = headRec[REC_W-33 -: 5];
    assign out_wdata = headRec[REC_W-38 -: 32];
    assign out_we    = headRec[19:16];
    assign out_seq   = headRec[15:0];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = dropCnt_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer
//
// Testbench for wb_trace_buffer. It drives inputs on the falling clock edge
// and samples outputs there too. A queue holds the expected records: a
// record is pushed when a qualifying capture is driven, and it is popped and
// compared when the consumer takes the head. Short vector tables and a few
// hand-written sequences cover the corner cases.
module tb_wb_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [31:0]       debug_wb_pc = '0;
    logic [3:0]        debug_wb_rf_we = '0;
    logic [4:0]        debug_wb_rf_wnum = '0;
    logic [31:0]       debug_wb_rf_wdata = '0;
    logic              capture_en = 1'b0;
    logic              clr = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_pc;
    logic [4:0]        out_wnum;
    logic [31:0]       out_wdata;
    logic [3:0]        out_we;
    logic [15:0]       out_seq;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [15:0]       drop_cnt;

    wb_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILTER_R0(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .capture_en(capture_en), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_wnum(out_wnum), .out_wdata(out_wdata),
        .out_we(out_we), .out_seq(out_seq),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic [15:0] seq;
    } traceRec_t;

    typedef struct {
        logic        capEn;
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic        ready;
        logic        expValid;
        logic [4:0]  expCount;
        logic [4:0]  expWnum;
        logic [31:0] expWdata;
        logic [15:0] expSeq;
    } vector_t;

    traceRec_t expQ[$];
    vector_t   vectors[8];
    int        errorCount = 0;
    int        checkCount = 0;
    int        mSeq = 0;
    int        mDrop = 0;
    logic      mOverflow = 1'b0;

    // Compare one value and report a mismatch.
    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Compare the DUT status outputs against the reference state.
    task automatic checkOutput();
        checkValue("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
        checkValue("count", 32'(count), 32'(expQ.size()));
        checkValue("overflow", 32'(overflow), 32'(mOverflow));
        checkValue("drop_cnt", 32'(drop_cnt), 32'(mDrop));
    endtask

    // Called on a falling edge. It checks the current state, drives one cycle
    // of inputs and updates the reference, then advances to the next falling
    // edge.
    task automatic applyStimulus(input logic capEn, input logic [3:0] we,
                                 input logic [4:0] wnum, input logic [31:0] pc,
                                 input logic [31:0] wdata, input logic ready,
                                 input logic clrIn);
        traceRec_t rec;
        bit        cap;
        bit        pop;
        checkOutput();
        capture_en        = capEn;
        debug_wb_rf_we    = we;
        debug_wb_rf_wnum  = wnum;
        debug_wb_pc       = pc;
        debug_wb_rf_wdata = wdata;
        out_ready         = ready;
        clr               = clrIn;
        cap = capEn && (we != 4'd0) && (wnum != 5'd0);
        pop = (expQ.size() != 0) && ready;
        if (clrIn) begin
            expQ.delete();
            mSeq      = 0;
            mDrop     = 0;
            mOverflow = 1'b0;
        end else begin
            if (pop) begin
                rec = expQ.pop_front();
                checkValue("pop out_pc", out_pc, rec.pc);
                checkValue("pop out_wnum", 32'(out_wnum), 32'(rec.wnum));
                checkValue("pop out_wdata", out_wdata, rec.wdata);
                checkValue("pop out_we", 32'(out_we), 32'(rec.we));
                checkValue("pop out_seq", 32'(out_seq), 32'(rec.seq));
            end
            if (cap) begin
                if (expQ.size() < DEPTH) begin
                    rec = '{pc, wnum, wdata, we, 16'(mSeq)};
                    expQ.push_back(rec);
                end else begin
                    mOverflow = 1'b1;
                    if (mDrop < 65535) mDrop++;
                end
                mSeq = (mSeq + 1) % 65536;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleInputs();
        capture_en     = 1'b0;
        debug_wb_rf_we = 4'd0;
        out_ready      = 1'b0;
        clr            = 1'b0;
    endtask

    // Pulse reset around one falling edge and clear the reference state.
    task automatic resetDut();
        idleInputs();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        expQ.delete();
        mSeq      = 0;
        mDrop     = 0;
        mOverflow = 1'b0;
        @(negedge clk);
    endtask

    task automatic writeRec(input int i, input logic ready);
        applyStimulus(1'b1, 4'hF, 5'((i % 31) + 1), 32'h1c000000 + 32'(i * 4),
                      32'(i), ready, 1'b0);
    endtask

    task automatic drainAll();
        for (int k = 0; k < 2 * DEPTH && expQ.size() != 0; k++) begin
            applyStimulus(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        checkOutput();
    endtask

    initial begin
        vectors[0] = '{1'b1, 4'hF, 5'd5,  32'h1c000000, 32'hDEADBEEF, 1'b0,
                       1'b1, 5'd1, 5'd5,  32'hDEADBEEF, 16'd0};
        vectors[1] = '{1'b1, 4'h0, 5'd0,  32'h0,        32'h0,        1'b1,
                       1'b0, 5'd0, 5'd0,  32'h0,        16'd0};
        vectors[2] = '{1'b1, 4'hF, 5'd0,  32'h1c000010, 32'h11111111, 1'b0,
                       1'b0, 5'd0, 5'd0,  32'h0,        16'd0};
        vectors[3] = '{1'b1, 4'h0, 5'd3,  32'h1c000014, 32'h22222222, 1'b0,
                       1'b0, 5'd0, 5'd0,  32'h0,        16'd0};
        vectors[4] = '{1'b0, 4'hF, 5'd7,  32'h1c000018, 32'h33333333, 1'b0,
                       1'b0, 5'd0, 5'd0,  32'h0,        16'd0};
        vectors[5] = '{1'b1, 4'h3, 5'd9,  32'h1c000004, 32'h12345678, 1'b0,
                       1'b1, 5'd1, 5'd9,  32'h12345678, 16'd1};
        vectors[6] = '{1'b1, 4'h1, 5'd10, 32'h1c000008, 32'h0000AAAA, 1'b1,
                       1'b1, 5'd1, 5'd10, 32'h0000AAAA, 16'd2};
        vectors[7] = '{1'b0, 4'h0, 5'd0,  32'h0,        32'h0,        1'b1,
                       1'b0, 5'd0, 5'd0,  32'h0,        16'd0};

        // Reset state, including zeroed head data.
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkValue("reset out_valid", 32'(out_valid), 32'd0);
        checkValue("reset count", 32'(count), 32'd0);
        checkValue("reset drop_cnt", 32'(drop_cnt), 32'd0);
        checkValue("reset out_pc", out_pc, 32'd0);
        checkValue("reset out_wdata", out_wdata, 32'd0);
        checkValue("reset out_seq", 32'(out_seq), 32'd0);

        // Single capture, filtering and the same-cycle pop/push of one entry.
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vectors[v].capEn, vectors[v].we, vectors[v].wnum,
                          vectors[v].pc, vectors[v].wdata, vectors[v].ready, 1'b0);
            checkValue($sformatf("vec%0d out_valid", v), 32'(out_valid),
                       32'(vectors[v].expValid));
            checkValue($sformatf("vec%0d count", v), 32'(count),
                       32'(vectors[v].expCount));
            if (vectors[v].expValid) begin
                checkValue($sformatf("vec%0d out_wnum", v), 32'(out_wnum),
                           32'(vectors[v].expWnum));
                checkValue($sformatf("vec%0d out_wdata", v), out_wdata,
                           vectors[v].expWdata);
                checkValue($sformatf("vec%0d out_seq", v), 32'(out_seq),
                           32'(vectors[v].expSeq));
            end
        end

        // Fill past full, then drain in order.
        resetDut();
        for (int i = 0; i < 20; i++) writeRec(i, 1'b0);
        idleInputs();
        checkValue("fill count", 32'(count), 32'd16);
        checkValue("fill overflow", 32'(overflow), 32'd1);
        checkValue("fill drop_cnt", 32'(drop_cnt), 32'd4);
        for (int i = 0; i < 16; i++) begin
            checkValue("drain wdata", out_wdata, 32'(i));
            checkValue("drain seq", 32'(out_seq), 32'(i));
            applyStimulus(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        writeRec(100, 1'b0);
        checkValue("post-drop seq", 32'(out_seq), 32'd20);
        drainAll();

        // Full FIFO with simultaneous push and pop, across the pointer wrap.
        resetDut();
        for (int i = 0; i < 16; i++) writeRec(i, 1'b0);
        for (int i = 16; i < 24; i++) begin
            writeRec(i, 1'b1);
            checkValue("pushpop count", 32'(count), 32'd16);
            checkValue("pushpop drop_cnt", 32'(drop_cnt), 32'd0);
        end
        checkValue("pushpop head seq", 32'(out_seq), 32'd8);
        drainAll();

        // clr with a coincident capture.
        resetDut();
        for (int i = 0; i < 19; i++) writeRec(i, 1'b0);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        checkValue("pre-clr count", 32'(count), 32'd5);
        checkValue("pre-clr drop_cnt", 32'(drop_cnt), 32'd3);
        applyStimulus(1'b1, 4'hF, 5'd4, 32'h1c000100, 32'h0BADF00D, 1'b1, 1'b1);
        idleInputs();
        checkValue("clr count", 32'(count), 32'd0);
        checkValue("clr out_valid", 32'(out_valid), 32'd0);
        checkValue("clr overflow", 32'(overflow), 32'd0);
        checkValue("clr drop_cnt", 32'(drop_cnt), 32'd0);
        applyStimulus(1'b1, 4'hF, 5'd6, 32'h1c000200, 32'h00000055, 1'b0, 1'b0);
        checkValue("post-clr seq", 32'(out_seq), 32'd0);
        checkValue("post-clr wdata", out_wdata, 32'h55);
        drainAll();

        // Asynchronous reset asserted between clock edges.
        resetDut();
        for (int i = 0; i < 7; i++) writeRec(i, 1'b0);
        idleInputs();
        checkValue("pre-reset count", 32'(count), 32'd7);
        #2;
        resetn = 1'b0;
        #1;
        checkValue("async out_valid", 32'(out_valid), 32'd0);
        checkValue("async count", 32'(count), 32'd0);
        expQ.delete();
        mSeq      = 0;
        mDrop     = 0;
        mOverflow = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 4'hF, 5'd2, 32'h1c000300, 32'h00000077, 1'b0, 1'b0);
        checkValue("post-reset seq", 32'(out_seq), 32'd0);
        drainAll();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
